// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer: state encoding,
// counter widths and a phase-index width helper.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int SETTLE_W = 8;
  localparam int WDOG_W   = 16;

  // Width of an index selecting one of n units; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between top-level control (master) and the phase
// sequencer (slave).
interface phase_sequencer_if #(
  parameter int NUM_UNITS = 2,
  parameter int ITER_W    = 16
);
  import phase_seq_pkg::*;

  localparam int PH_W = idx_w(NUM_UNITS);

  logic                 start;
  logic                 abort;
  logic                 finish;
  logic                 halt_in;
  logic [NUM_UNITS-1:0] unit_reset;
  logic [PH_W-1:0]      phase;
  logic [ITER_W-1:0]    iter_count;
  logic                 busy;
  logic                 done;
  logic                 wdog_err;

  modport master (
    output start, abort, finish, halt_in,
    input  unit_reset, phase, iter_count, busy, done, wdog_err
  );

  modport slave (
    input  start, abort, finish, halt_in,
    output unit_reset, phase, iter_count, busy, done, wdog_err
  );

endinterface

// File: rtl/phase_sequencer_timer.sv
// phase_timer: loadable down-counter with a zero flag; stops at zero and
// reloads whenever load_i is asserted (load wins over count).
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Releases one compute unit from reset at a time, with a settle gap between
// phases. Optional per-phase watchdog: define PHASE_WATCHDOG_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_UNITS     = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int ITER_W        = 16,
  parameter int MAX_ITER      = 0,
  parameter int WDOG_LIMIT    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  phase_sequencer_if.slave   bus
);

  localparam int                   PH_W      = idx_w(NUM_UNITS);
  localparam logic [PH_W-1:0]      LAST_PH   = PH_W'(NUM_UNITS - 1);
  localparam logic [ITER_W-1:0]    MAX_IT    = ITER_W'(MAX_ITER);
  localparam logic [NUM_UNITS-1:0] MASK0     = ~NUM_UNITS'(1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LD = SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e               state_q;
  logic [PH_W-1:0]      phase_q;
  logic [ITER_W-1:0]    iter_q;
  logic [NUM_UNITS-1:0] unit_reset_q;
  logic                 busy_q, done_q, wdog_q;

  logic                 wrap_s, limit_hit_s, settle_zero_s, wd_fire_s;
  logic [PH_W-1:0]      next_phase_s;
  logic [ITER_W-1:0]    next_iter_s;
  logic [NUM_UNITS-1:0] run_mask_s;

  // Where the sequence goes when the current phase's gap has elapsed.
  always_comb begin
    wrap_s       = (phase_q == LAST_PH);
    next_phase_s = wrap_s ? '0 : phase_q + PH_W'(1);
    next_iter_s  = wrap_s ? iter_q + ITER_W'(1) : iter_q;
    limit_hit_s  = wrap_s && (MAX_IT != '0) && (next_iter_s == MAX_IT);
    run_mask_s   = '1;
    run_mask_s[next_phase_s] = 1'b0;
  end

  phase_timer #(.W(SETTLE_W)) u_settle (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     ((state_q == ST_RUN) && bus.finish),
    .load_val_i (SETTLE_LD),
    .en_i       (state_q == ST_SETTLE),
    .zero_o     (settle_zero_s)
  );

`ifdef PHASE_WATCHDOG_EN
  logic wd_zero_s;

  // Reloaded outside RUN and on every finish, so each RUN phase starts a fresh budget.
  phase_timer #(.W(WDOG_W)) u_wdog (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     ((state_q != ST_RUN) || bus.finish),
    .load_val_i (WDOG_W'(WDOG_LIMIT - 1)),
    .en_i       (state_q == ST_RUN),
    .zero_o     (wd_zero_s)
  );

  assign wd_fire_s = wd_zero_s;
`else
  assign wd_fire_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      iter_q       <= '0;
      unit_reset_q <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wdog_q       <= 1'b0;
    end else if (bus.abort) begin
      state_q      <= ST_IDLE;
      unit_reset_q <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wdog_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q      <= ST_RUN;
            phase_q      <= '0;
            iter_q       <= '0;
            unit_reset_q <= MASK0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            wdog_q       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.halt_in) begin
            state_q      <= ST_DONE;
            unit_reset_q <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else if (bus.finish) begin
            if (SETTLE_CYCLES == 0) begin
              state_q      <= limit_hit_s ? ST_DONE : ST_RUN;
              phase_q      <= next_phase_s;
              iter_q       <= next_iter_s;
              unit_reset_q <= limit_hit_s ? '1 : run_mask_s;
              busy_q       <= !limit_hit_s;
              done_q       <= limit_hit_s;
            end else begin
              state_q      <= ST_SETTLE;
              unit_reset_q <= '1;
            end
          end else if (wd_fire_s) begin
            state_q      <= ST_DONE;
            unit_reset_q <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            wdog_q       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (bus.halt_in) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else if (settle_zero_s) begin
            state_q      <= limit_hit_s ? ST_DONE : ST_RUN;
            phase_q      <= next_phase_s;
            iter_q       <= next_iter_s;
            unit_reset_q <= limit_hit_s ? '1 : run_mask_s;
            busy_q       <= !limit_hit_s;
            done_q       <= limit_hit_s;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          unit_reset_q <= '1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unit_reset = unit_reset_q;
  assign bus.phase      = phase_q;
  assign bus.iter_count = iter_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wdog_err   = wdog_q;

endmodule
